serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial adder that sums two WIDTH-bit operands LSB-first, one bit per clock, through a single full-adder cell built from two half-adder stages and a registered carry. It sits directly downstream of the combinational half-adder cells: it consumes their sum/carry behaviour bit by bit and turns them into a multi-cycle, handshaked N-bit addition. It is used where area matters more than latency.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse; high while in DONE.
- sum  output  WIDTH  registered result, (a+b+cin) mod 2^WIDTH.
- cout  output  1  registered carry-out of the addition.

## Operation
- Internal state:
  - operand shift registers a_sr and b_sr
  - result shift register s_sr
  - carry flop c
  - bit counter cnt, width ceil(log2(WIDTH))
  - FSM state
- Full-adder cell:
  - half-adder 1 on (a_sr[0], b_sr[0]) gives p and g1.
  - half-adder 2 on (p, c) gives bit and g2.
  - next carry = g1 | g2.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0.
  - If start=1 at an edge: load a_sr=a, b_sr=b, c=cin, cnt=0, s_sr=0, and go to SHIFT.
  - If start=0: stay in IDLE.
- SHIFT:
  - busy=1.
  - Each edge: s_sr shifts right with bit inserted at MSB; a_sr and b_sr shift right with zero fill; c takes the next carry; cnt increments.
  - On the edge where cnt==WIDTH-1 (the WIDTH-th shift), go to DONE.
  - On that same edge, sum takes the fully shifted result (s_sr after insertion) and cout takes the next carry.
- DONE:
  - done=1, busy=0.
  - The next edge returns to IDLE unconditionally.
  - start is ignored in DONE.
- sum and cout change only on entry to DONE. They hold their value through IDLE and the next SHIFT until the next DONE.
- start asserted while busy or in DONE is ignored. There is no queuing. Changes to a, b or cin after acceptance have no effect.
- Reset (rst_n=0, at any time, including mid-SHIFT), asynchronously:
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - all shift registers, c and cnt are cleared.
  - The aborted operation produces no done pulse.
- Release of rst_n is synchronous to clk. The first possible accept is the first rising edge with rst_n=1.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0.
- The accepting edge is edge E.
  - busy is high from E until edge E+WIDTH.
  - done is high from E+WIDTH until E+WIDTH+1.
  - sum and cout are valid from E+WIDTH.
- Latency from accept to done is WIDTH cycles.
- Minimum spacing between accepts is WIDTH+2 cycles (SHIFT×WIDTH, DONE, then IDLE).
- If start is held high continuously, accepts occur every WIDTH+2 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- WIDTH=8; a=0x5A, b=0x3C, cin=0; start pulsed at edge E → busy high for 8 cycles, done at E+8, sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- Result hold and ignored start:
  - After the 0x5A+0x3C result, start a new op with a=0x01, b=0x01; sum stays 0x96 through SHIFT and becomes 0x02 at done.
  - Pulse start again at E+3 of this op → ignored; exactly one done pulse occurs.
- Reset mid-operation:
  - Assert rst_n=0 at E+3 of 0xAA+0x55 → busy, done, sum and cout are 0 immediately; no done follows.
  - After release, 0x10+0x20 gives sum=0x30 at the expected cycle.
- start held high for 30 cycles with a=0x01, b=0x02, cin=0 → accepts at edges 0, 10, 20; done at 8, 18, 28; sum=0x03 each time.
- WIDTH=2 instance: a=3, b=3, cin=1 → done 2 cycles after accept, sum=3, cout=1.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: sums two WIDTH-bit operands LSB-first, one bit per clock,
// through a single full-adder cell (two half-adder stages + registered carry).
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic             c;
    logic [CW-1:0]    cnt;

    logic             p;
    logic             g1;
    logic             s_bit;
    logic             g2;
    logic             c_next;
    logic [WIDTH-1:0] s_next;

    // Full-adder cell from two half-adders, plus the shifted result it produces
    always_comb begin
        p      = a_sr[0] ^ b_sr[0];
        g1     = a_sr[0] & b_sr[0];
        s_bit  = p ^ c;
        g2     = p & c;
        c_next = g1 | g2;
        s_next = {s_bit, s_sr[WIDTH-1:1]};
    end

    // Control FSM, datapath shift registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        c     <= cin;
                        cnt   <= '0;
                        s_sr  <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    s_sr <= s_next;
                    c    <= c_next;
                    cnt  <= cnt + CW'(1);
                    // Last bit: publish the result and pulse done
                    if (cnt == LAST) begin
                        sum   <= s_next;
                        cout  <= c_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8 and WIDTH=2 instances).
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start2;
    logic [1:0] a2;
    logic [1:0] b2;
    logic       cin2;
    logic       busy2;
    logic       done2;
    logic [1:0] sum2;
    logic       cout2;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] hold_s;
    logic       hold_c;
    int         done_cnt;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=8 operation; optional extra start pulse at E+pulse_at
    task automatic do_op(input logic [7:0] oa, input logic [7:0] ob, input logic oc,
                         input logic [7:0] es, input logic ec, input int pulse_at);
        a = oa; b = ob; cin = oc; start = 1'b1;
        tick();                                 // edge E
        start = 1'b0;
        a = ~oa; b = ~ob; cin = ~oc;            // late changes must not matter
        for (int k = 1; k <= 8; k++) begin
            chk("busy_shift", 32'(busy), 32'd1);
            chk("done_shift", 32'(done), 32'd0);
            chk("sum_hold",   32'(sum),  32'(hold_s));
            chk("cout_hold",  32'(cout), 32'(hold_c));
            start = (k == pulse_at);
            tick();                             // edge E+k
        end
        start = 1'b0;
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_done",  32'(busy), 32'd0);
        chk("sum_result", 32'(sum),  32'(es));
        chk("cout_result",32'(cout), 32'(ec));
        tick();
        chk("done_clear", 32'(done), 32'd0);
        chk("busy_idle",  32'(busy), 32'd0);
        chk("sum_kept",   32'(sum),  32'(es));
        hold_s = es;
        hold_c = ec;
        if (pulse_at > 0) begin
            for (int k = 0; k < 12; k++) begin
                tick();
                chk("no_extra_done", 32'(done), 32'd0);
                chk("no_extra_busy", 32'(busy), 32'd0);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
        hold_s = 8'h00; hold_c = 1'b0;
        tick(); tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum",  32'(sum),  32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        do_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 0);
        do_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 3);
        do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
        do_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0);

        // Reset in the middle of 0xAA+0x55
        a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
        tick();                                 // edge E
        start = 1'b0;
        tick(); tick();                         // after E+2
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_sum",  32'(sum),  32'd0);
        chk("arst_cout", 32'(cout), 32'd0);
        tick(); tick();
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done) done_cnt++;
            if (busy) done_cnt++;
        end
        chk("aborted_silent", 32'(done_cnt), 32'd0);
        hold_s = 8'h00; hold_c = 1'b0;
        do_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 0);

        // start held high: accepts at edges 0, 10, 20
        a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();                             // after edge i
            chk("held_busy", 32'(busy), ((i % 10) < 8) ? 32'd1 : 32'd0);
            chk("held_done", 32'(done), ((i % 10) == 8) ? 32'd1 : 32'd0);
            if ((i % 10) == 8) chk("held_sum", 32'(sum), 32'h03);
            if (done) done_cnt++;
        end
        start = 1'b0;
        chk("held_done_count", 32'(done_cnt), 32'd3);

        // WIDTH=2 instance: 3+3+1
        a2 = 2'd3; b2 = 2'd3; cin2 = 1'b1; start2 = 1'b1;
        tick();                                 // edge E
        start2 = 1'b0;
        chk("w2_busy0", 32'(busy2), 32'd1);
        chk("w2_done0", 32'(done2), 32'd0);
        tick();
        chk("w2_busy1", 32'(busy2), 32'd1);
        chk("w2_done1", 32'(done2), 32'd0);
        tick();
        chk("w2_done",  32'(done2), 32'd1);
        chk("w2_busy2", 32'(busy2), 32'd0);
        chk("w2_sum",   32'(sum2),  32'd3);
        chk("w2_cout",  32'(cout2), 32'd1);
        tick();
        chk("w2_done_clear", 32'(done2), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
